// File: rtl/proj_divider_wb_initiator_if.sv
// Wishbone classic bus bundle between the divider initiator (master) and the
// divider CSR block (slave).
interface proj_divider_wb_initiator_if #(
  parameter int unsigned WBW = 32
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [WBW/8-1:0] sel;
  logic [WBW-1:0]   adr;
  logic [WBW-1:0]   dat_w;
  logic [WBW-1:0]   dat_r;
  logic             ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack
  );
endinterface

// File: rtl/proj_divider_wb_initiator.sv
// Wishbone initiator that runs one full division on the serial-divider CSR block:
// write operands, start, poll FINI, read quotient and remainder, report done/err.
module proj_divider_wb_initiator #(
  parameter int unsigned    WBW         = 32,
  parameter int unsigned    XLEN        = 32,
  parameter logic [WBW-1:0] BASE_ADR    = WBW'(32'h3000_0000),
  parameter int unsigned    ACK_TIMEOUT = 16,
  parameter int unsigned    POLL_MAX    = 64,
  parameter int unsigned    POLL_GAP    = 2
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            req_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            ready_o,
  output logic            done_o,
  output logic            err_o,
  output logic [1:0]      err_code_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  proj_divider_wb_initiator_if.master wbm
);

  localparam int unsigned AckW  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned PollW = $clog2(POLL_MAX + 1);
  localparam int unsigned GapW  = $clog2(POLL_GAP + 1);

  localparam logic [AckW-1:0]  AckLast  = AckW'(ACK_TIMEOUT - 1);
  localparam logic [PollW-1:0] PollLast = PollW'(POLL_MAX - 1);
  localparam logic [GapW-1:0]  GapLoad  = GapW'(POLL_GAP - 1);

  localparam logic [WBW-1:0] AdrDvd   = BASE_ADR;
  localparam logic [WBW-1:0] AdrDvs   = BASE_ADR + WBW'(32'h04);
  localparam logic [WBW-1:0] AdrQuo   = BASE_ADR + WBW'(32'h08);
  localparam logic [WBW-1:0] AdrRem   = BASE_ADR + WBW'(32'h0C);
  localparam logic [WBW-1:0] AdrFini  = BASE_ADR + WBW'(32'h14);
  localparam logic [WBW-1:0] AdrStart = BASE_ADR + WBW'(32'h18);

  typedef enum logic [3:0] {
    StIdle,
    StWrDvd,
    StWrDvs,
    StWrStart,
    StRdFini,
    StRdQuo,
    StRdRem,
    StDone,
    StErr
  } state_e;

  state_e            state_q;
  logic              cyc_q;
  logic              we_q;
  logic [WBW-1:0]    adr_q;
  logic [WBW-1:0]    dat_q;
  logic [AckW-1:0]   ack_cnt_q;
  logic [PollW-1:0]  poll_cnt_q;
  logic [GapW-1:0]   gap_q;
  logic [XLEN-1:0]   dvd_q;
  logic [XLEN-1:0]   dvs_q;
  logic [XLEN-1:0]   quo_cap_q;
  logic [XLEN-1:0]   quotient_q;
  logic [XLEN-1:0]   remainder_q;
  logic              ready_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        err_code_q;

  logic              acc_we;
  logic [WBW-1:0]    acc_adr;
  logic [WBW-1:0]    acc_dat;

  // Access attributes of the bus state we are in; loaded when its cycle starts.
  always_comb begin
    acc_we  = 1'b0;
    acc_adr = '0;
    acc_dat = '0;
    unique case (state_q)
      StWrDvd:   begin acc_we = 1'b1; acc_adr = AdrDvd;   acc_dat = WBW'(dvd_q); end
      StWrDvs:   begin acc_we = 1'b1; acc_adr = AdrDvs;   acc_dat = WBW'(dvs_q); end
      StWrStart: begin acc_we = 1'b1; acc_adr = AdrStart; end
      StRdFini:  acc_adr = AdrFini;
      StRdQuo:   acc_adr = AdrQuo;
      StRdRem:   acc_adr = AdrRem;
      default:   ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      ack_cnt_q   <= '0;
      poll_cnt_q  <= '0;
      gap_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_cap_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_i) begin
            ready_q    <= 1'b0;
            dvd_q      <= dividend_i;
            dvs_q      <= divisor_i;
            poll_cnt_q <= '0;
            gap_q      <= '0;
            // Divisors 0 and 1 never let the responder finish; refuse without bus traffic.
            if (divisor_i[XLEN-1:1] == '0) begin
              err_q      <= 1'b1;
              err_code_q <= 2'b11;
              state_q    <= StErr;
            end else begin
              err_code_q <= 2'b00;
              state_q    <= StWrDvd;
              cyc_q      <= 1'b1;
              we_q       <= 1'b1;
              adr_q      <= AdrDvd;
              dat_q      <= WBW'(dividend_i);
              ack_cnt_q  <= '0;
            end
          end
        end
        StWrDvd, StWrDvs, StWrStart, StRdFini, StRdQuo, StRdRem: begin
          if (!cyc_q) begin
            if (gap_q == '0) begin
              cyc_q     <= 1'b1;
              we_q      <= acc_we;
              adr_q     <= acc_adr;
              dat_q     <= acc_dat;
              ack_cnt_q <= '0;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end else if (wbm.ack) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            gap_q <= '0;
            case (state_q)
              StWrDvd:   state_q <= StWrDvs;
              StWrDvs:   state_q <= StWrStart;
              StWrStart: begin
                state_q <= StRdFini;
                gap_q   <= GapLoad;
              end
              StRdFini: begin
                if (wbm.dat_r[0]) begin
                  state_q <= StRdQuo;
                end else if (poll_cnt_q == PollLast) begin
                  err_q      <= 1'b1;
                  err_code_q <= 2'b10;
                  state_q    <= StErr;
                end else begin
                  poll_cnt_q <= poll_cnt_q + 1'b1;
                  gap_q      <= GapLoad;
                end
              end
              StRdQuo: begin
                quo_cap_q <= wbm.dat_r[XLEN-1:0];
                state_q   <= StRdRem;
              end
              StRdRem: begin
                quotient_q  <= quo_cap_q;
                remainder_q <= wbm.dat_r[XLEN-1:0];
                done_q      <= 1'b1;
                state_q     <= StDone;
              end
              default: ;
            endcase
          end else if (ack_cnt_q == AckLast) begin
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            err_q      <= 1'b1;
            err_code_q <= 2'b01;
            state_q    <= StErr;
          end else begin
            ack_cnt_q <= ack_cnt_q + 1'b1;
          end
        end
        StDone, StErr: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign wbm.cyc   = cyc_q;
  assign wbm.stb   = cyc_q;
  assign wbm.we    = we_q;
  assign wbm.sel   = {(WBW/8){cyc_q}};
  assign wbm.adr   = adr_q;
  assign wbm.dat_w = dat_q;

  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule

// File: tb/tb_proj_divider_wb_initiator.sv
// Directed bench for the divider Wishbone initiator: a behavioural CSR responder
// plus a result scoreboard checked whenever done_o/err_o fires.
module tb_proj_divider_wb_initiator;

  localparam logic [31:0] Base = 32'h3000_0000;
  localparam logic [31:0] NoHold = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        ready, done, err;
  logic [1:0]  err_code;
  logic [31:0] quo, rem;

  proj_divider_wb_initiator_if #(.WBW(32)) wb ();

  proj_divider_wb_initiator dut (
    .clk_i       (clk),
    .reset_ni    (rst_n),
    .req_i       (req),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .ready_o     (ready),
    .done_o      (done),
    .err_o       (err),
    .err_code_o  (err_code),
    .quotient_o  (quo),
    .remainder_o (rem),
    .wbm         (wb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected completions.
  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [31:0] quo;
    logic [31:0] rem;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected completion", {30'd0, err, done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("completion kind err", {31'd0, err}, {31'd0, e.is_err});
        check("completion kind done", {31'd0, done}, {31'd0, !e.is_err});
        if (e.is_err) begin
          check("err_code", {30'd0, err_code}, {30'd0, e.code});
        end else begin
          check("quotient", quo, e.quo);
          check("remainder", rem, e.rem);
        end
      end
    end
  end

  // Responder: acks one negedge after a cycle starts unless the address is withheld.
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    int          cyc;
  } acc_t;
  acc_t        log_q[$];
  logic [31:0] hold_adr = NoHold;
  int          fini_after = 3;
  int          poll_n = 0;
  int          ncyc = 0;
  logic [31:0] m_dvd = '0;
  logic [31:0] m_dvs = 32'd1;

  initial begin
    wb.ack   = 1'b0;
    wb.dat_r = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (wb.cyc && wb.stb && !wb.ack && wb.adr != hold_adr) begin
        wb.ack = 1'b1;
        log_q.push_back('{adr: wb.adr, we: wb.we, dat: wb.dat_w, cyc: ncyc});
        wb.dat_r = '0;
        if (wb.we) begin
          if (wb.adr == Base)         m_dvd = wb.dat_w;
          if (wb.adr == Base + 32'h4) m_dvs = wb.dat_w;
          if (wb.adr == Base + 32'h18) poll_n = 0;
        end else begin
          if (wb.adr == Base + 32'h14) begin
            poll_n++;
            wb.dat_r = {31'd0, (fini_after != 0 && poll_n >= fini_after)};
          end
          if (wb.adr == Base + 32'h08) wb.dat_r = m_dvd / m_dvs;
          if (wb.adr == Base + 32'h0C) wb.dat_r = m_dvd % m_dvs;
        end
      end else begin
        wb.ack = 1'b0;
      end
    end
  end

  // Bus protocol watch: stb/sel track cyc, attributes stable while cyc is held.
  logic        p_cyc = 1'b0;
  logic [31:0] p_adr, p_dat;
  logic        p_we;
  int          run = 0;
  int          last_run = 0;
  logic        cyc_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wb.cyc) cyc_seen = 1'b1;
      if (wb.stb !== wb.cyc) check("stb equals cyc", {31'd0, wb.stb}, {31'd0, wb.cyc});
      if (wb.sel !== {4{wb.cyc}}) check("sel lanes", {28'd0, wb.sel}, {28'd0, {4{wb.cyc}}});
      if (wb.cyc && p_cyc) begin
        check("adr stable", wb.adr, p_adr);
        check("dat stable", wb.dat_w, p_dat);
        check("we stable", {31'd0, wb.we}, {31'd0, p_we});
      end
      if (wb.cyc) begin
        run++;
      end else if (run != 0) begin
        last_run = run;
        run = 0;
      end
    end
    p_cyc = wb.cyc;
    p_adr = wb.adr;
    p_dat = wb.dat_w;
    p_we  = wb.we;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    req      = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, ready}, 32'd1);
  endtask

  task automatic push_done(input logic [31:0] q, input logic [31:0] r);
    exp_q.push_back('{is_err: 1'b0, code: 2'b00, quo: q, rem: r});
  endtask

  task automatic push_err(input logic [1:0] c);
    exp_q.push_back('{is_err: 1'b1, code: c, quo: '0, rem: '0});
  endtask

  logic [31:0] t1_adr [8];
  logic        t1_we  [8];

  initial begin
    int bad;
    int npoll;
    bit found;
    t1_adr = '{Base, Base + 32'h4, Base + 32'h18, Base + 32'h14, Base + 32'h14,
               Base + 32'h14, Base + 32'h08, Base + 32'h0C};
    t1_we  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset ready", {31'd0, ready}, 32'd1);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset err_code", {30'd0, err_code}, 32'd0);
    check("reset quotient", quo, 32'd0);
    check("reset remainder", rem, 32'd0);
    check("reset cyc", {31'd0, wb.cyc}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: normal division, FINI on third poll.
    fini_after = 3;
    log_q.delete();
    push_done(32'h40, 32'h0);
    issue(32'h100, 32'd4);
    wait_ready("t1 completes");
    check("t1 access count", log_q.size(), 32'd8);
    if (log_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t1 adr[%0d]", i), log_q[i].adr, t1_adr[i]);
        check($sformatf("t1 we[%0d]", i), {31'd0, log_q[i].we}, {31'd0, t1_we[i]});
      end
      check("t1 dvd data", log_q[0].dat, 32'h100);
      check("t1 dvs data", log_q[1].dat, 32'h4);
      check("t1 start data", log_q[2].dat, 32'h0);
      check("t1 first poll gap", {31'd0, (log_q[3].cyc - log_q[2].cyc) >= 3}, 32'd1);
    end

    // 2: divisor of 1 is refused without bus activity.
    cyc_seen = 1'b0;
    push_err(2'b11);
    issue(32'h1234, 32'd1);
    check("t2 ready low after accept", {31'd0, ready}, 32'd0);
    check("t2 err pulse", {31'd0, err}, 32'd1);
    @(negedge clk);
    check("t2 ready back", {31'd0, ready}, 32'd1);
    check("t2 err single", {31'd0, err}, 32'd0);
    check("t2 err_code held", {30'd0, err_code}, 32'd3);
    check("t2 no bus cycle", {31'd0, cyc_seen}, 32'd0);
    check("t2 quotient kept", quo, 32'h40);

    // 3: ack withheld on DIVISOR write -> timeout, then a clean retry.
    hold_adr = Base + 32'h4;
    log_q.delete();
    push_err(2'b01);
    issue(32'h30, 32'd3);
    wait_ready("t3 abort");
    check("t3 stb held cycles", last_run, 32'd16);
    check("t3 err_code", {30'd0, err_code}, 32'd1);
    check("t3 accesses logged", log_q.size(), 32'd1);
    check("t3 cyc low", {31'd0, wb.cyc}, 32'd0);
    hold_adr = NoHold;
    push_done(32'h10, 32'h0);
    issue(32'h30, 32'd3);
    wait_ready("t3 retry");
    check("t3 err_code cleared", {30'd0, err_code}, 32'd0);

    // 4: FINI never set -> poll limit.
    fini_after = 0;
    log_q.delete();
    push_err(2'b10);
    issue(32'h55, 32'd5);
    wait_ready("t4 abort");
    npoll = 0;
    bad = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      if (log_q[i].adr == Base + 32'h14) begin
        npoll++;
        if (i > 3 && (log_q[i].cyc - log_q[i-1].cyc) != 3) bad++;
      end
    end
    check("t4 poll reads", npoll, 32'd64);
    check("t4 poll spacing", bad, 32'd0);
    check("t4 total accesses", log_q.size(), 32'd67);
    check("t4 err_code", {30'd0, err_code}, 32'd2);
    check("t4 quotient kept", quo, 32'h10);

    // 5: reset mid FINI access.
    issue(32'h77, 32'd7);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (wb.cyc && wb.adr == Base + 32'h14) found = 1'b1;
      else @(negedge clk);
    end
    check("t5 reached FINI poll", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5 cyc dropped", {31'd0, wb.cyc}, 32'd0);
    check("t5 stb dropped", {31'd0, wb.stb}, 32'd0);
    check("t5 ready", {31'd0, ready}, 32'd1);
    check("t5 quotient reset", quo, 32'd0);
    check("t5 err_code reset", {30'd0, err_code}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fini_after = 1;
    push_done(32'h40, 32'h0);
    issue(32'h80, 32'd2);
    wait_ready("t5 after reset");

    // 6: ignored mid-op request, then a request held across done.
    fini_after = 2;
    push_done(32'h30, 32'h0);
    issue(32'h90, 32'd3);
    repeat (4) @(negedge clk);
    dividend = 32'hDEAD;
    divisor  = 32'd7;
    req      = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    push_done(32'hE, 32'h2);
    dividend = 32'h64;
    divisor  = 32'd7;
    req      = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("t6 first done", {31'd0, found}, 32'd1);
    @(negedge clk);
    check("t6 ready after done", {31'd0, ready}, 32'd1);
    check("t6 idle cycle", {31'd0, wb.cyc}, 32'd0);
    @(negedge clk);
    req = 1'b0;
    check("t6 second WR_DVD cyc", {31'd0, wb.cyc}, 32'd1);
    check("t6 second WR_DVD adr", wb.adr, Base);
    check("t6 second WR_DVD dat", wb.dat_w, 32'h64);
    wait_ready("t6 second op");
    repeat (3) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
